// File: rtl/clk_en_gen.sv
// Multi-channel phase-accumulator clock-enable generator with a PLL-style lock indicator.
// Optional feature: define CLKEN_PHASE_ALIGN_EN to reset every accumulator on each valid config write.
module clk_en_gen #(
    parameter int unsigned       NUM_CH      = 2,
    parameter int unsigned       ACC_W       = 32,
    parameter int unsigned       LOCK_CYCLES = 16,
    parameter logic [ACC_W-1:0]  DEF_INC     = ACC_W'(32'h80A3_D70A),
    localparam int unsigned      CH_W        = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              refclk_i,
    input  logic              rst_n,
    input  logic [NUM_CH-1:0] en_i,
    input  logic              cfg_we_i,
    input  logic [CH_W-1:0]   cfg_ch_i,
    input  logic [ACC_W-1:0]  cfg_inc_i,
    output logic [NUM_CH-1:0] tick_o,
    output logic              locked_o
);

    localparam int unsigned LCNT_W = (LOCK_CYCLES > 1) ? $clog2(LOCK_CYCLES) : 1;

    typedef enum logic [1:0] {
        StRst,
        StSettle,
        StLocked
    } lock_state_e;

    logic [ACC_W-1:0]  acc_q [NUM_CH];
    logic [ACC_W-1:0]  acc_d [NUM_CH];
    logic [ACC_W-1:0]  inc_q [NUM_CH];
    logic [ACC_W-1:0]  inc_d [NUM_CH];
    logic [ACC_W:0]    sum   [NUM_CH];
    logic [NUM_CH-1:0] tick_q, tick_d;
    lock_state_e       state_q, state_d;
    logic [LCNT_W-1:0] lcnt_q, lcnt_d;
    logic              cfg_valid;

    // Writes aimed at a non-existent channel must leave everything untouched.
    assign cfg_valid = cfg_we_i && (32'(cfg_ch_i) < NUM_CH);

    always_comb begin
        tick_d = '0;
        for (int c = 0; c < int'(NUM_CH); c++) begin
            sum[c]   = {1'b0, acc_q[c]} + {1'b0, inc_q[c]};
            acc_d[c] = acc_q[c];
            inc_d[c] = inc_q[c];
            if (en_i[c]) begin
                acc_d[c]  = sum[c][ACC_W-1:0];
                tick_d[c] = sum[c][ACC_W];
            end
`ifdef CLKEN_PHASE_ALIGN_EN
            if (cfg_valid) begin
                acc_d[c]  = '0;
                tick_d[c] = 1'b0;
            end
`endif
            // The old increment is still used for this cycle's addition above.
            if (cfg_valid && (32'(cfg_ch_i) == 32'(c))) begin
                inc_d[c] = cfg_inc_i;
            end
        end
    end

    always_ff @(posedge refclk_i or negedge rst_n) begin
        if (!rst_n) begin
            for (int c = 0; c < int'(NUM_CH); c++) begin
                acc_q[c] <= '0;
                inc_q[c] <= DEF_INC;
            end
            tick_q <= '0;
        end else begin
            for (int c = 0; c < int'(NUM_CH); c++) begin
                acc_q[c] <= acc_d[c];
                inc_q[c] <= inc_d[c];
            end
            tick_q <= tick_d;
        end
    end

    always_comb begin
        state_d = state_q;
        lcnt_d  = lcnt_q;
        unique case (state_q)
            StRst: begin
                state_d = StSettle;
                lcnt_d  = '0;
            end
            StSettle: begin
                if (cfg_valid) begin
                    lcnt_d = '0;
                end else if (lcnt_q == LCNT_W'(LOCK_CYCLES - 1)) begin
                    state_d = StLocked;
                end else begin
                    lcnt_d = lcnt_q + LCNT_W'(1);
                end
            end
            StLocked: begin
                if (cfg_valid) begin
                    state_d = StSettle;
                    lcnt_d  = '0;
                end
            end
            default: begin
                state_d = StRst;
                lcnt_d  = '0;
            end
        endcase
    end

    always_ff @(posedge refclk_i or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StRst;
            lcnt_q  <= '0;
        end else begin
            state_q <= state_d;
            lcnt_q  <= lcnt_d;
        end
    end

    assign tick_o   = tick_q;
    assign locked_o = (state_q == StLocked);

endmodule

// File: tb/tb_clk_en_gen.sv
// Randomised self-checking bench for clk_en_gen against an arithmetic reference model.
// Build with CLKEN_PHASE_ALIGN_EN defined to exercise the phase-align variant.
module tb_clk_en_gen;

    localparam int          NCH = 3;
    localparam int          LC  = 16;
    localparam logic [31:0] DEF = 32'h80A3_D70A;

    logic           refclk = 1'b0;
    logic           rst_n  = 1'b0;
    logic [NCH-1:0] en     = '0;
    logic           cfg_we = 1'b0;
    logic [1:0]     cfg_ch = '0;
    logic [31:0]    cfg_inc = '0;
    logic [NCH-1:0] tick;
    logic           locked;

    int checks   = 0;
    int failures = 0;

    always #5 refclk = ~refclk;

    clk_en_gen #(
        .NUM_CH      (NCH),
        .ACC_W       (32),
        .LOCK_CYCLES (LC),
        .DEF_INC     (DEF)
    ) dut (
        .refclk_i  (refclk),
        .rst_n     (rst_n),
        .en_i      (en),
        .cfg_we_i  (cfg_we),
        .cfg_ch_i  (cfg_ch),
        .cfg_inc_i (cfg_inc),
        .tick_o    (tick),
        .locked_o  (locked)
    );

    // Reference: phase as plain integer arithmetic, lock as "edges since last settle trigger".
    longint unsigned m_acc [NCH];
    longint unsigned m_inc [NCH];
    logic [NCH-1:0]  m_tick;
    int              m_age;

    always @(posedge refclk or negedge rst_n) begin
        if (!rst_n) begin
            for (int c = 0; c < NCH; c++) begin
                m_acc[c] = 0;
                m_inc[c] = 64'(DEF);
            end
            m_tick = '0;
            m_age  = 0;
        end else begin
            bit              valid;
            longint unsigned s;
            valid = cfg_we && (int'(cfg_ch) < NCH);
            for (int c = 0; c < NCH; c++) begin
                s = m_acc[c] + m_inc[c];
                if (en[c]) begin
                    m_tick[c] = (s >= 64'h1_0000_0000);
                    m_acc[c]  = s & 64'hFFFF_FFFF;
                end else begin
                    m_tick[c] = 1'b0;
                end
            end
`ifdef CLKEN_PHASE_ALIGN_EN
            if (valid) begin
                for (int c = 0; c < NCH; c++) m_acc[c] = 0;
                m_tick = '0;
            end
`endif
            if (valid) begin
                m_inc[cfg_ch] = 64'(cfg_inc);
                m_age = 1;
            end else if (m_age < 1000) begin
                m_age = m_age + 1;
            end
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge refclk) begin
        check("tick_vs_model", 64'(tick), 64'(m_tick));
        check("locked_vs_model", 64'(locked), 64'(m_age >= LC + 1));
    end

    task automatic cfg_write(input logic [1:0] ch, input logic [31:0] v);
        @(negedge refclk);
        cfg_we  = 1'b1;
        cfg_ch  = ch;
        cfg_inc = v;
        @(negedge refclk);
        cfg_we  = 1'b0;
    endtask

    // Release reset between edges and pin the lock edge: low after edge 16, high after edge 17.
    task automatic release_and_lock();
        @(negedge refclk);
        rst_n = 1'b1;
        for (int k = 1; k <= LC + 1; k++) begin
            @(negedge refclk);
            if (k == LC) check("locked_edge16", 64'(locked), 64'd0);
            if (k == LC + 1) check("locked_edge17", 64'(locked), 64'd1);
        end
    endtask

    task automatic lock_drop_check();
        check("lock_drop_now", 64'(locked), 64'd0);
        repeat (LC - 1) @(negedge refclk);
        check("lock_drop_last", 64'(locked), 64'd0);
        @(negedge refclk);
        check("lock_regained", 64'(locked), 64'd1);
    endtask

    task automatic count_ticks(input int n, output int c0, output int c1, output int odd1);
        c0 = 0;
        c1 = 0;
        odd1 = 0;
        repeat (n) begin
            @(negedge refclk);
            c0 += int'(tick[0]);
            c1 += int'(tick[1]);
            if (tick[1] && !tick[0]) odd1++;
        end
    endtask

    initial begin
        int cnt [NCH];
        int c0, c1, odd1, n;

        en = '1;
        repeat (3) @(negedge refclk);
        check("reset_tick", 64'(tick), 64'd0);
        check("reset_locked", 64'(locked), 64'd0);
        release_and_lock();

        // Default increment: 1005 ticks per channel in the 2000 cycles after lock.
        for (int c = 0; c < NCH; c++) cnt[c] = 0;
        repeat (2000) begin
            @(negedge refclk);
            for (int c = 0; c < NCH; c++) cnt[c] += int'(tick[c]);
        end
        for (int c = 0; c < NCH; c++) check("default_rate_ticks", 64'(cnt[c]), 64'd1005);

        cfg_write(2'd0, 32'h8000_0000);
        lock_drop_check();
        cfg_write(2'd1, 32'h4000_0000);
        lock_drop_check();
        count_ticks(40, c0, c1, odd1);
        check("ch0_half_rate", 64'(c0), 64'd20);
        check("ch1_quarter_rate", 64'(c1), 64'd10);
`ifdef CLKEN_PHASE_ALIGN_EN
        check("ch1_coincides_ch0", 64'(odd1), 64'd0);
`endif

        cfg_write(2'd3, 32'h1234_5678);
        check("bad_ch_keeps_lock", 64'(locked), 64'd1);
        count_ticks(40, c0, c1, odd1);
        check("bad_ch_ch0_rate", 64'(c0), 64'd20);
        check("bad_ch_ch1_rate", 64'(c1), 64'd10);
        check("bad_ch_still_locked", 64'(locked), 64'd1);

        @(negedge refclk);
        en[0] = 1'b0;
        n = 0;
        repeat (10) begin
            @(negedge refclk);
            n += int'(tick[0]);
        end
        en[0] = 1'b1;
        check("en_drop_no_ticks", 64'(n), 64'd0);
        repeat (20) @(negedge refclk);

        repeat (800) begin
            @(negedge refclk);
            en     = NCH'($urandom);
            cfg_we = ($urandom_range(0, 15) == 0);
            cfg_ch = 2'($urandom_range(0, 3));
            case ($urandom_range(0, 3))
                0:       cfg_inc = 32'h0;
                1:       cfg_inc = $urandom;
                2:       cfg_inc = 32'h8000_0000 | $urandom;
                default: cfg_inc = $urandom >> 4;
            endcase
        end
        @(negedge refclk);
        cfg_we = 1'b0;
        en     = '1;

        // Async reset while ch0 is ticking and the FSM is locked.
        cfg_write(2'd0, 32'h8000_0000);
        n = 0;
        while (!locked && n < 40) begin
            @(negedge refclk);
            n++;
        end
        n = 0;
        while (!tick[0] && n < 4) begin
            @(negedge refclk);
            n++;
        end
        check("pre_rst_tick", 64'(tick[0]), 64'd1);
        check("pre_rst_locked", 64'(locked), 64'd1);
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_tick", 64'(tick), 64'd0);
        check("async_rst_locked", 64'(locked), 64'd0);
        repeat (3) @(negedge refclk);
        release_and_lock();
        repeat (50) @(negedge refclk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
